// File: rtl/compare_search4.sv
// Binary-search controller driving a three-way comparator: guess in, gt/eq/lt back.
// Latency: start->first probe 1 cycle, each response consumed on its sampling edge, last response->done 1 cycle.
// Backpressure: guess is held with guess_valid high until resp_valid is sampled; start ignored while probing.
module compare_search4 #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    output logic [WIDTH-1:0] guess,
    output logic             guess_valid,
    input  logic             resp_valid,
    input  logic             aGrtb,
    input  logic             aEqb,
    input  logic             aLessb,
    output logic             busy,
    output logic             done,
    output logic             found,
    output logic             error,
    output logic [WIDTH-1:0] result,
    output logic [2:0]       probe_count
);

    localparam logic [WIDTH:0] MAX = {1'b0, {WIDTH{1'b1}}};

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PROBE = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH:0]   lo_q, lo_d, hi_q, hi_d, sum;
    logic [WIDTH-1:0] guess_q, guess_d, result_q, result_d;
    logic             found_q, found_d, error_q, error_d;
    logic [2:0]       count_q, count_d;
    logic             one_hot, empty;

    assign one_hot = ({aGrtb, aEqb, aLessb} == 3'b100) ||
                     ({aGrtb, aEqb, aLessb} == 3'b010) ||
                     ({aGrtb, aEqb, aLessb} == 3'b001);

    always_comb begin
        state_d  = state_q;
        lo_d     = lo_q;
        hi_d     = hi_q;
        guess_d  = guess_q;
        result_d = result_q;
        found_d  = found_q;
        error_d  = error_q;
        count_d  = count_q;
        sum      = '0;
        empty    = 1'b0;
        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d  = PROBE;
                    lo_d     = '0;
                    hi_d     = MAX;
                    guess_d  = MAX[WIDTH:1];
                    count_d  = 3'd1;
                    found_d  = 1'b0;
                    error_d  = 1'b0;
                    result_d = '0;
                end
            end
            PROBE: begin
                if (resp_valid) begin
                    if (!one_hot) begin
                        state_d  = DONE;
                        error_d  = 1'b1;
                        found_d  = 1'b0;
                        result_d = '0;
                    end else if (aEqb) begin
                        state_d  = DONE;
                        found_d  = 1'b1;
                        result_d = guess_q;
                    end else begin
                        if (aGrtb) begin
                            hi_d  = {1'b0, guess_q} - 1'b1;
                            // guess 0 implies lo 0, so hi = -1 means an empty range
                            empty = (guess_q == '0) || (lo_q > hi_d);
                        end else begin
                            lo_d  = {1'b0, guess_q} + 1'b1;
                            empty = lo_d > hi_q;
                        end
                        if (empty) begin
                            state_d  = DONE;
                            found_d  = 1'b0;
                            error_d  = 1'b0;
                            result_d = '0;
                        end else begin
                            sum     = lo_d + hi_d;
                            guess_d = sum[WIDTH:1];
                            count_d = count_q + 3'd1;
                        end
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            lo_q     <= '0;
            hi_q     <= MAX;
            guess_q  <= '0;
            result_q <= '0;
            found_q  <= 1'b0;
            error_q  <= 1'b0;
            count_q  <= '0;
        end else begin
            state_q  <= state_d;
            lo_q     <= lo_d;
            hi_q     <= hi_d;
            guess_q  <= guess_d;
            result_q <= result_d;
            found_q  <= found_d;
            error_q  <= error_d;
            count_q  <= count_d;
        end
    end

    assign guess       = guess_q;
    assign guess_valid = (state_q == PROBE);
    assign busy        = (state_q == PROBE);
    assign done        = (state_q == DONE);
    assign found       = found_q;
    assign error       = error_q;
    assign result      = result_q;
    assign probe_count = count_q;

endmodule
